// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: parity modes, FSM states and frame sizing.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    // Total bits on the line for one frame, start bit included.
    function automatic int unsigned frame_bits(int unsigned data_bits, int unsigned parity,
                                               int unsigned stop_bits);
        int unsigned par_bits;
        par_bits = (parity != PARITY_NONE) ? 32'd1 : 32'd0;
        return 32'd1 + data_bits + par_bits + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last cycle of each bit.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 103
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic CLEAR,
    output logic BIT_DONE
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (CLEAR || (cnt_q == CntMax)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign BIT_DONE = (cnt_q == CntMax);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word input, one-word holding buffer, configurable
// data width, parity and stop bits, LSB-first serialisation onto a registered TX line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 103,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic [DATA_BITS-1:0] DATA,
    input  logic                 VALID,
    output logic                 READY,
    output logic                 TX,
    output logic                 BUSY
);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $fatal(1, "uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $fatal(1, "uart_tx: DATA_BITS must be in 5..9");
    end
    if (PARITY > PARITY_EVEN) begin : g_bad_parity
        $fatal(1, "uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic [3:0]           bit_cnt_q;
    logic                 par_q;
    logic                 tx_q;

    logic bit_done;
    logic accept;
    logic frame_end;
    logic baud_clear;

    assign accept     = VALID && !hold_full_q;
    assign frame_end  = (state_q == StStop) && bit_done && (bit_cnt_q == LastStop);
    // Holding the counter at zero while idle makes every frame start phase-aligned.
    assign baud_clear = (state_q == StIdle);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .CLKIN   (CLKIN),
        .RESET   (RESET),
        .CLEAR   (baud_clear),
        .BIT_DONE(bit_done)
    );

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            // A word accepted mid-frame waits in the buffer, unless the frame is ending now.
            if (accept && (state_q != StIdle) && !frame_end) begin
                hold_q      <= DATA;
                hold_full_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        shift_q <= DATA;
                        par_q   <= 1'b0;
                        tx_q    <= 1'b0;
                        state_q <= StStart;
                    end
                end

                StStart: begin
                    if (bit_done) begin
                        tx_q      <= shift_q[0];
                        par_q     <= par_q ^ shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                    end
                end

                StData: begin
                    if (bit_done) begin
                        if (bit_cnt_q == LastData) begin
                            bit_cnt_q <= '0;
                            if (PARITY != PARITY_NONE) begin
                                tx_q    <= (PARITY == PARITY_ODD) ? ~par_q : par_q;
                                state_q <= StParity;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StStop;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            par_q     <= par_q ^ shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end

                StParity: begin
                    if (bit_done) begin
                        tx_q      <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= StStop;
                    end
                end

                StStop: begin
                    if (bit_done) begin
                        if (bit_cnt_q == LastStop) begin
                            bit_cnt_q <= '0;
                            if (hold_full_q) begin
                                shift_q     <= hold_q;
                                hold_full_q <= 1'b0;
                                par_q       <= 1'b0;
                                tx_q        <= 1'b0;
                                state_q     <= StStart;
                            end else if (accept) begin
                                shift_q <= DATA;
                                par_q   <= 1'b0;
                                tx_q    <= 1'b0;
                                state_q <= StStart;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= StIdle;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign READY = !hold_full_q;
    assign TX    = tx_q;
    assign BUSY  = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four parameter sets run side by side against a frame-level model
// that predicts TX, READY and BUSY every cycle, plus directed frame checks.
module tb_uart_tx;

    localparam int NCfg = 4;
    localparam int unsigned CPB [NCfg] = '{103, 4, 4, 3};
    localparam int unsigned DB  [NCfg] = '{8, 7, 8, 9};
    localparam int unsigned PAR [NCfg] = '{0, 2, 1, 0};
    localparam int unsigned SB  [NCfg] = '{1, 2, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCfg-1:0] rst;
    logic [NCfg-1:0] valid;
    logic [8:0]      data [NCfg];

    logic tx_0, tx_1, tx_2, tx_3;
    logic rdy_0, rdy_1, rdy_2, rdy_3;
    logic busy_0, busy_1, busy_2, busy_3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the frame currently on the line as a bit vector plus a cycle index.
    logic        m_active [NCfg];
    int          m_cyc    [NCfg];
    logic [15:0] m_bits   [NCfg];
    logic        m_hold_f [NCfg];
    logic [8:0]  m_hold_w [NCfg];

    uart_tx u_dut0 (
        .CLKIN(clk), .RESET(rst[0]), .DATA(data[0][7:0]), .VALID(valid[0]),
        .READY(rdy_0), .TX(tx_0), .BUSY(busy_0)
    );

    uart_tx #(
        .CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) u_dut1 (
        .CLKIN(clk), .RESET(rst[1]), .DATA(data[1][6:0]), .VALID(valid[1]),
        .READY(rdy_1), .TX(tx_1), .BUSY(busy_1)
    );

    uart_tx #(
        .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
    ) u_dut2 (
        .CLKIN(clk), .RESET(rst[2]), .DATA(data[2][7:0]), .VALID(valid[2]),
        .READY(rdy_2), .TX(tx_2), .BUSY(busy_2)
    );

    uart_tx #(
        .CLKS_PER_BIT(3), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)
    ) u_dut3 (
        .CLKIN(clk), .RESET(rst[3]), .DATA(data[3]), .VALID(valid[3]),
        .READY(rdy_3), .TX(tx_3), .BUSY(busy_3)
    );

    function automatic logic tx_of(int i);
        case (i)
            0: return tx_0;
            1: return tx_1;
            2: return tx_2;
            default: return tx_3;
        endcase
    endfunction

    function automatic logic rdy_of(int i);
        case (i)
            0: return rdy_0;
            1: return rdy_1;
            2: return rdy_2;
            default: return rdy_3;
        endcase
    endfunction

    function automatic logic busy_of(int i);
        case (i)
            0: return busy_0;
            1: return busy_1;
            2: return busy_2;
            default: return busy_3;
        endcase
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(int i);
        return 1 + int'(DB[i]) + ((PAR[i] != 0) ? 1 : 0) + int'(SB[i]);
    endfunction

    // Line image of one frame, bit 0 first; positions past the parity bit stay 1 (stop).
    function automatic logic [15:0] frame_of(int i, logic [8:0] w);
        logic [15:0] f;
        logic [8:0]  mw;
        int          pos;
        int          ones;
        mw   = w & ((9'h1 << DB[i]) - 9'h1);
        ones = $countones(mw);
        f    = '1;
        f[0] = 1'b0;
        for (int k = 0; k < int'(DB[i]); k++) f[1 + k] = mw[k];
        pos = 1 + int'(DB[i]);
        if (PAR[i] == 1) f[pos] = (ones % 2 == 0);
        if (PAR[i] == 2) f[pos] = (ones % 2 == 1);
        return f;
    endfunction

    task automatic start_frame(int i, logic [8:0] w);
        m_bits[i]   = frame_of(i, w);
        m_cyc[i]    = 0;
        m_active[i] = 1'b1;
    endtask

    task automatic model_edge(int i, logic acc);
        if (rst[i]) begin
            m_active[i] = 1'b0;
            m_hold_f[i] = 1'b0;
        end else begin
            if (m_active[i]) begin
                m_cyc[i]++;
                if (m_cyc[i] == frame_len(i) * int'(CPB[i])) m_active[i] = 1'b0;
            end
            if (!m_active[i]) begin
                if (m_hold_f[i]) begin
                    start_frame(i, m_hold_w[i]);
                    m_hold_f[i] = 1'b0;
                end else if (acc) begin
                    start_frame(i, data[i]);
                end
            end else if (acc) begin
                m_hold_w[i] = data[i];
                m_hold_f[i] = 1'b1;
            end
        end
    endtask

    task automatic step();
        logic acc [NCfg];
        logic exp_tx;
        for (int i = 0; i < NCfg; i++) acc[i] = valid[i] && !m_hold_f[i];
        @(posedge clk);
        for (int i = 0; i < NCfg; i++) model_edge(i, acc[i]);
        @(negedge clk);
        for (int i = 0; i < NCfg; i++) begin
            exp_tx = m_active[i] ? m_bits[i][m_cyc[i] / int'(CPB[i])] : 1'b1;
            check_eq($sformatf("tx[%0d]", i), 32'(tx_of(i)), 32'(exp_tx));
            check_eq($sformatf("ready[%0d]", i), 32'(rdy_of(i)), 32'(!m_hold_f[i]));
            check_eq($sformatf("busy[%0d]", i), 32'(busy_of(i)),
                     32'(m_active[i] || m_hold_f[i]));
        end
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic push(int i, logic [8:0] w);
        valid[i] = 1'b1;
        data[i]  = w;
        step();
        valid[i] = 1'b0;
    endtask

    task automatic wait_idle(int i, int budget);
        int n;
        n = 0;
        while (busy_of(i) && n < budget) begin
            step();
            n++;
        end
        check_eq($sformatf("idle_in_budget[%0d]", i), 32'(busy_of(i)), 32'd0);
    endtask

    initial begin
        logic [9:0]  pat_8n1;
        logic [10:0] pat_7e2;
        logic [8:0]  par_words [3];
        logic        par_exp [3];
        int          p;

        pat_8n1 = 10'b1010101010;
        pat_7e2 = 11'b11000000110;
        par_words = '{9'h0FF, 9'h000, 9'h001};
        par_exp   = '{1'b1, 1'b1, 1'b0};

        for (int i = 0; i < NCfg; i++) begin
            m_active[i] = 1'b0;
            m_cyc[i]    = 0;
            m_bits[i]   = '1;
            m_hold_f[i] = 1'b0;
            m_hold_w[i] = '0;
            data[i]     = '0;
        end
        valid = '0;
        rst   = '1;
        run(2);
        rst = '0;
        for (int i = 0; i < NCfg; i++) begin
            check_eq($sformatf("reset_tx[%0d]", i), 32'(tx_of(i)), 32'd1);
            check_eq($sformatf("reset_ready[%0d]", i), 32'(rdy_of(i)), 32'd1);
            check_eq($sformatf("reset_busy[%0d]", i), 32'(busy_of(i)), 32'd0);
        end

        // Single 8N1 frame of 0x55.
        push(0, 9'h055);
        check_eq("8n1_latency", 32'(tx_0), 32'd0);
        for (int b = 0; b < 10; b++) begin
            run((b == 0) ? 51 : 103);
            check_eq($sformatf("8n1_bit%0d", b), 32'(tx_0), 32'(pat_8n1[b]));
        end
        run(51);
        check_eq("8n1_busy_1029", 32'(busy_0), 32'd1);
        run(1);
        check_eq("8n1_busy_1030", 32'(busy_0), 32'd0);

        // Back-to-back 0x41 then 0x42.
        push(0, 9'h041);
        run(10);
        push(0, 9'h042);
        check_eq("b2b_ready_low", 32'(rdy_0), 32'd0);
        check_eq("b2b_busy", 32'(busy_0), 32'd1);
        run(1018);
        check_eq("b2b_last_stop", 32'(tx_0), 32'd1);
        run(1);
        check_eq("b2b_no_gap", 32'(tx_0), 32'd0);
        check_eq("b2b_ready_rise", 32'(rdy_0), 32'd1);
        wait_idle(0, 1200);

        // 7 data bits, even parity, 2 stop bits.
        push(1, 9'h003);
        for (int b = 0; b < 11; b++) begin
            run((b == 0) ? 2 : 4);
            check_eq($sformatf("7e2_bit%0d", b), 32'(tx_1), 32'(pat_7e2[b]));
        end
        run(1);
        check_eq("7e2_busy_43", 32'(busy_1), 32'd1);
        run(1);
        check_eq("7e2_busy_44", 32'(busy_1), 32'd0);

        // Odd parity bit values.
        for (int w = 0; w < 3; w++) begin
            wait_idle(2, 200);
            push(2, par_words[w]);
            run(38);
            check_eq($sformatf("odd_parity_%0h", par_words[w]), 32'(tx_2), 32'(par_exp[w]));
        end
        wait_idle(2, 200);

        // Reset mid-data-bit with a word held.
        push(1, 9'h015);
        run(4);
        push(1, 9'h02A);
        check_eq("rst_held_ready", 32'(rdy_1), 32'd0);
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        check_eq("rst_tx", 32'(tx_1), 32'd1);
        check_eq("rst_ready", 32'(rdy_1), 32'd1);
        check_eq("rst_busy", 32'(busy_1), 32'd0);
        for (int k = 0; k < 60; k++) begin
            step();
            check_eq("rst_no_held_tx", 32'(tx_1), 32'd1);
        end

        // Accept on the edge that ends the final stop bit.
        push(1, 9'h055);
        run(43);
        valid[1] = 1'b1;
        data[1]  = 9'h02B;
        step();
        valid[1] = 1'b0;
        check_eq("coincide_start", 32'(tx_1), 32'd0);
        check_eq("coincide_ready", 32'(rdy_1), 32'd1);
        check_eq("coincide_busy", 32'(busy_1), 32'd1);
        run(43);
        check_eq("coincide_busy_87", 32'(busy_1), 32'd1);
        run(1);
        check_eq("coincide_once", 32'(busy_1), 32'd0);

        // Random traffic: dense phase then sparse phase, with rare resets.
        for (int c = 0; c < 6000; c++) begin
            p = (c < 3000) ? 70 : 4;
            for (int i = 0; i < NCfg; i++) begin
                valid[i] = ($urandom_range(0, 99) < p);
                data[i]  = 9'($urandom);
                rst[i]   = ($urandom_range(0, 1999) == 0);
            end
            step();
        end
        valid = '0;
        rst   = '0;
        for (int i = 0; i < NCfg; i++) wait_idle(i, 2500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
